// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite bus codes, SRAM slave FSM states and the byte-lane helpers
// used by the SRAM slave and its bench.
package ahb_lite_sram_slave_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ERR1,
      ST_ERR2
   } sram_state_t;

   function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] lane);
      case (size)
         HSIZE_BYTE: return 4'b0001 << lane;
         HSIZE_HALF: return 4'b0011 << lane;
         default:    return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
      logic [31:0] m;
      m = old_word;
      for (int unsigned i = 0; i < 4; i++)
         if (strb[i]) m[8*i +: 8] = new_word[8*i +: 8];
      return m;
   endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_array.sv
// DEPTH x 32 word storage: byte-enabled synchronous write, combinational read.
module ahb_lite_sram_array #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 4; i++)
         if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave fronting a word-organised SRAM: sized reads/writes, optional
// wait states, two-cycle ERROR response for illegal accesses.
module ahb_lite_sram_slave
   import ahb_lite_sram_slave_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [1:0]  HTRANS,
   input  logic        HMASTLOCK,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP
);

   localparam int unsigned AW = $clog2(DEPTH);

   sram_state_t   state;
   logic [3:0]    wait_cnt;
   logic          dp_valid;
   logic          dp_write;
   logic          dp_err;
   logic [2:0]    dp_size;
   logic [AW+1:0] dp_addr;

   logic          accept;
   logic          addr_err;
   logic          commit;
   logic [3:0]    wstrb;
   logic [31:0]   mem_rdata;
   logic [31:0]   rd_word;
   logic          unused_inputs;

   assign unused_inputs = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

   assign accept   = HSEL & HREADY & HTRANS[1] & HREADYOUT;
   assign addr_err = (HADDR >= 32'(DEPTH * 4))
                   | (HSIZE > HSIZE_WORD)
                   | ((HSIZE == HSIZE_HALF) & HADDR[0])
                   | ((HSIZE == HSIZE_WORD) & (|HADDR[1:0]));

   assign commit = dp_valid & dp_write & ~dp_err & HREADYOUT;
   assign wstrb  = commit ? byte_strobe(dp_size, dp_addr[1:0]) : '0;

   // A read accepted on the edge that commits a write to the same word would
   // otherwise see the pre-write array contents.
   assign rd_word = (commit && (dp_addr[AW+1:2] == HADDR[AW+1:2]))
                  ? merge_bytes(mem_rdata, HWDATA, wstrb) : mem_rdata;

   ahb_lite_sram_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (HCLK),
      .we    (wstrb),
      .waddr (dp_addr[AW+1:2]),
      .wdata (HWDATA),
      .raddr (HADDR[AW+1:2]),
      .rdata (mem_rdata)
   );

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state     <= ST_IDLE;
         HREADYOUT <= 1'b1;
         HRESP     <= HRESP_OKAY;
         HRDATA    <= '0;
         wait_cnt  <= '0;
         dp_valid  <= 1'b0;
         dp_write  <= 1'b0;
         dp_err    <= 1'b0;
         dp_size   <= '0;
         dp_addr   <= '0;
      end else if (!HREADYOUT) begin
         case (state)
            ST_WAIT: begin
               wait_cnt  <= wait_cnt - 4'd1;
               HREADYOUT <= (wait_cnt == 4'd1);
            end
            ST_ERR1: begin
               state     <= ST_ERR2;
               HREADYOUT <= 1'b1;
            end
            default: HREADYOUT <= 1'b1;
         endcase
      end else if (accept) begin
         dp_valid <= 1'b1;
         dp_write <= HWRITE;
         dp_err   <= addr_err;
         dp_size  <= HSIZE;
         dp_addr  <= HADDR[AW+1:0];
         if (addr_err) begin
            state     <= ST_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
         end else begin
            HRESP <= HRESP_OKAY;
            if (!HWRITE) HRDATA <= rd_word;
            if (WAIT_STATES == 0) begin
               state <= ST_IDLE;
            end else begin
               state     <= ST_WAIT;
               wait_cnt  <= 4'(WAIT_STATES);
               HREADYOUT <= 1'b0;
            end
         end
      end else begin
         state    <= ST_IDLE;
         HRESP    <= HRESP_OKAY;
         dp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: two instances (0 and 3 wait states) on one
// shared bus, table-driven beats checked through an expectation queue.
module tb_ahb_lite_sram_slave;
   import ahb_lite_sram_slave_pkg::*;

   localparam logic [1:0] NS = HTRANS_NONSEQ;
   localparam logic [1:0] SQ = HTRANS_SEQ;
   localparam logic [2:0] SB = HSIZE_BYTE;
   localparam logic [2:0] SH = HSIZE_HALF;
   localparam logic [2:0] SW = HSIZE_WORD;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        hsel = 1'b0, hwrite = 1'b0, which = 1'b0, hready_block = 1'b0;
   logic [1:0]  htrans = HTRANS_IDLE;
   logic [2:0]  hsize = HSIZE_WORD;
   logic [31:0] haddr = '0, hwdata = '0;

   logic [31:0] rd0, rd3, rdata_obs;
   logic        ro0, ro3, rs0, rs3;
   logic        ready_obs, resp_obs, hready_bus;

   always #5 clk = ~clk;

   assign ready_obs  = which ? ro3 : ro0;
   assign resp_obs   = which ? rs3 : rs0;
   assign rdata_obs  = which ? rd3 : rd0;
   assign hready_bus = hready_block ? 1'b0 : ready_obs;

   ahb_lite_sram_slave #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel & ~which), .HADDR(haddr), .HWRITE(hwrite),
      .HSIZE(hsize), .HBURST(HBURST_SINGLE), .HPROT(4'b0011), .HTRANS(htrans),
      .HMASTLOCK(1'b0), .HREADY(hready_bus), .HWDATA(hwdata),
      .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0));

   ahb_lite_sram_slave #(.DEPTH(256), .WAIT_STATES(3)) dut3 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel & which), .HADDR(haddr), .HWRITE(hwrite),
      .HSIZE(hsize), .HBURST(HBURST_SINGLE), .HPROT(4'b0011), .HTRANS(htrans),
      .HMASTLOCK(1'b0), .HREADY(hready_bus), .HWDATA(hwdata),
      .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rs3));

   typedef struct {
      logic        rd;
      logic        err;
      logic [31:0] data;
      int unsigned waits;
   } exp_t;

   typedef struct {
      logic        w;
      logic [1:0]  tr;
      logic        wr;
      logic [2:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
      logic        err;
      logic [31:0] rd;
   } vec_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   vec_t        vt[19];
   int unsigned checks = 0, passed = 0, wait_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (!rst && sbq.size() != 0) begin
         if (!ready_obs) begin
            wait_seen++;
            chk("wait_hresp", 32'(resp_obs), 32'(sbq[0].err));
         end else begin
            mon_e = sbq.pop_front();
            chk("wait_cycles", wait_seen, mon_e.waits);
            chk("hresp", 32'(resp_obs), 32'(mon_e.err));
            if (mon_e.rd && !mon_e.err) chk("hrdata", rdata_obs, mon_e.data);
            wait_seen = 0;
         end
      end
   end

   task automatic beat(input logic w, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic push,
                       input logic eerr, input logic [31:0] erd);
      logic ok;
      int   n;
      exp_t e;
      ok = 1'b0;
      n  = 0;
      which = w; hsel = 1'b1; htrans = tr; hwrite = wr; hsize = sz; haddr = a;
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = hready_bus;
         @(posedge clk);
         n++;
      end
      #1;
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      hwdata = wd;
      hsel   = 1'b0;
      htrans = HTRANS_IDLE;
      if (push && ok) begin
         e.rd    = ~wr;
         e.err   = eerr;
         e.data  = erd;
         e.waits = eerr ? 1 : (w ? 3 : 0);
         sbq.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         chk("drain_timeout", 32'(sbq.size()), 32'd0);
         sbq.delete();
      end
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      vt[0]  = '{1'b0, NS, 1'b1, SW,   32'h010, 32'hDEADBEEF, 1'b0, 32'h0};
      vt[1]  = '{1'b0, SQ, 1'b0, SW,   32'h010, 32'h0,        1'b0, 32'hDEADBEEF};
      vt[2]  = '{1'b0, NS, 1'b1, SW,   32'h020, 32'h0,        1'b0, 32'h0};
      vt[3]  = '{1'b0, NS, 1'b1, SB,   32'h021, 32'h0000AA00, 1'b0, 32'h0};
      vt[4]  = '{1'b0, SQ, 1'b1, SH,   32'h022, 32'h55660000, 1'b0, 32'h0};
      vt[5]  = '{1'b0, NS, 1'b0, SW,   32'h020, 32'h0,        1'b0, 32'h5566AA00};
      vt[6]  = '{1'b0, NS, 1'b0, SB,   32'h021, 32'h0,        1'b0, 32'h5566AA00};
      vt[7]  = '{1'b0, NS, 1'b0, SW,   32'h400, 32'h0,        1'b1, 32'h0};
      vt[8]  = '{1'b0, NS, 1'b0, SW,   32'h002, 32'h0,        1'b1, 32'h0};
      vt[9]  = '{1'b0, NS, 1'b1, 3'd3, 32'h010, 32'h12345678, 1'b1, 32'h0};
      vt[10] = '{1'b0, NS, 1'b1, SH,   32'h011, 32'hFFFFFFFF, 1'b1, 32'h0};
      vt[11] = '{1'b0, NS, 1'b0, SW,   32'h010, 32'h0,        1'b0, 32'hDEADBEEF};
      vt[12] = '{1'b0, NS, 1'b1, SW,   32'h3FC, 32'hCAFEF00D, 1'b0, 32'h0};
      vt[13] = '{1'b0, NS, 1'b1, SB,   32'h3FF, 32'h11000000, 1'b0, 32'h0};
      vt[14] = '{1'b0, NS, 1'b0, SW,   32'h3FC, 32'h0,        1'b0, 32'h11FEF00D};
      vt[15] = '{1'b1, NS, 1'b1, SW,   32'h004, 32'h0BADF00D, 1'b0, 32'h0};
      vt[16] = '{1'b1, NS, 1'b0, SW,   32'h004, 32'h0,        1'b0, 32'h0BADF00D};
      vt[17] = '{1'b1, NS, 1'b0, SW,   32'h400, 32'h0,        1'b1, 32'h0};
      vt[18] = '{1'b1, SQ, 1'b0, SH,   32'h006, 32'h0,        1'b0, 32'h0BADF00D};

      #2 rst = 1'b1;
      #1;
      chk("rst_hreadyout0", 32'(ro0), 32'd1);
      chk("rst_hresp0",     32'(rs0), 32'd0);
      chk("rst_hrdata0",    rd0,      32'd0);
      chk("rst_hreadyout3", 32'(ro3), 32'd1);
      chk("rst_hresp3",     32'(rs3), 32'd0);
      chk("rst_hrdata3",    rd3,      32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Back-to-back beats; drain only when switching instance.
      for (int i = 0; i < 19; i++) begin
         if (which != vt[i].w) drain();
         beat(vt[i].w, vt[i].tr, vt[i].wr, vt[i].sz, vt[i].a, vt[i].wd, 1'b1, vt[i].err, vt[i].rd);
      end
      drain();

      // NONSEQ held while bus HREADY is low, then unselected BUSY: neither may access.
      which = 1'b0;
      @(posedge clk); #1;
      hready_block = 1'b1; hsel = 1'b1; htrans = NS; hwrite = 1'b1; hsize = SW;
      haddr = 32'h010; hwdata = 32'h0BAD0BAD;
      repeat (3) begin
         @(negedge clk);
         chk("hold_hreadyout", 32'(ready_obs), 32'd1);
         chk("hold_hresp",     32'(resp_obs),  32'd0);
      end
      @(posedge clk); #1;
      hready_block = 1'b0; hsel = 1'b0; htrans = HTRANS_BUSY;
      repeat (3) begin
         @(negedge clk);
         chk("busy_hreadyout", 32'(ready_obs), 32'd1);
         chk("busy_hresp",     32'(resp_obs),  32'd0);
      end
      @(posedge clk); #1;
      htrans = HTRANS_IDLE;
      beat(1'b0, NS, 1'b0, SW, 32'h010, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
      drain();

      // Reset during a wait-state write must drop the write.
      beat(1'b1, NS, 1'b1, SW, 32'h008, 32'h11111111, 1'b1, 1'b0, 32'h0);
      drain();
      beat(1'b1, NS, 1'b1, SW, 32'h008, 32'h0, 1'b0, 1'b0, 32'h0);
      hwdata = 32'h22222222;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_hreadyout", 32'(ready_obs), 32'd1);
      chk("midrst_hresp",     32'(resp_obs),  32'd0);
      chk("midrst_hrdata",    rdata_obs,      32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      beat(1'b1, NS, 1'b0, SW, 32'h008, 32'h0, 1'b1, 1'b0, 32'h11111111);
      drain();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
